// File: rtl/fifo_bram_bridge.sv
// Elastic buffer from a 32-bit word stream into a single-port BRAM ring.
// A synchronous FIFO absorbs writes; every cycle with data pending pops one word into the BRAM port.
module fifo_bram_bridge #(
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_DEPTH_WORDS = 16384,
  parameter int FIFO_DEPTH       = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fifo_write_en,
  input  logic [BRAM_DATA_WIDTH-1:0]      fifo_write_data,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [BRAM_ADDR_WIDTH-3:0]      current_bram_address,
  output logic                            bram_clk,
  output logic                            bram_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]      bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]      bram_din,
  output logic                            bram_en,
  output logic [3:0]                      bram_we
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = BRAM_ADDR_WIDTH - 2;
  localparam int DW = BRAM_DATA_WIDTH;

  logic [DW-1:0]              mem_q [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       full_q, full_d;
  logic [AW-1:0]              waddr_q, waddr_d;
  logic                       en_q, en_d;
  logic [3:0]                 we_q, we_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]              din_q, din_d;
  logic                       push, pop;

  // Both decisions use pre-edge occupancy: a pop never frees a slot for a
  // same-edge write, and a word written into an empty FIFO is not popped yet.
  assign push = fifo_write_en && (count_q != CW'(FIFO_DEPTH));
  assign pop  = (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    waddr_d  = waddr_q;
    en_d     = 1'b0;
    we_d     = '0;
    addr_d   = addr_q;
    din_d    = din_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      en_d     = 1'b1;
      we_d     = '1;
      din_d    = mem_q[rd_ptr_q];
      addr_d   = {waddr_q, 2'b00};
      waddr_d  = (waddr_q == AW'(BRAM_DEPTH_WORDS - 1)) ? '0 : waddr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fifo_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      waddr_q  <= '0;
      en_q     <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      waddr_q  <= waddr_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign fifo_full            = full_q;
  assign fifo_count           = count_q;
  assign current_bram_address = waddr_q;
  assign bram_clk             = clk;
  assign bram_rst             = rst;
  assign bram_addr            = addr_q;
  assign bram_din             = din_q;
  assign bram_en              = en_q;
  assign bram_we              = we_q;

endmodule

// File: tb/tb_fifo_bram_bridge.sv
// Bench for fifo_bram_bridge: default instance plus a small ring/FIFO instance, both
// driven by the same stream and compared each cycle against a queue-based reference.
module tb_fifo_bram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_write_en = 1'b0;
  logic [31:0] fifo_write_data = '0;

  logic        full0, full1;
  logic [8:0]  count0;
  logic [2:0]  count1;
  logic [13:0] cur0, cur1;
  logic        bclk0, bclk1, brst0, brst1;
  logic [15:0] baddr0, baddr1;
  logic [31:0] bdin0, bdin1;
  logic        ben0, ben1;
  logic [3:0]  bwe0, bwe1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  fifo_bram_bridge dut0 (
    .clk(clk), .rst(rst), .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .fifo_full(full0), .fifo_count(count0), .current_bram_address(cur0),
    .bram_clk(bclk0), .bram_rst(brst0), .bram_addr(baddr0), .bram_din(bdin0),
    .bram_en(ben0), .bram_we(bwe0)
  );

  fifo_bram_bridge #(.BRAM_DEPTH_WORDS(16), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .fifo_full(full1), .fifo_count(count1), .current_bram_address(cur1),
    .bram_clk(bclk1), .bram_rst(brst1), .bram_addr(baddr1), .bram_din(bdin1),
    .bram_en(ben1), .bram_we(bwe1)
  );

  // Reference state: pending words per instance plus last BRAM-port values.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int unsigned m_next[2];
  logic        m_en[2];
  int unsigned m_baddr[2];
  logic [31:0] m_din[2];
  int unsigned ring_depth[2] = '{16384, 16};
  int unsigned fifo_depth[2] = '{256, 4};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int unsigned i, input logic r, input logic w, input logic [31:0] d);
    logic [31:0] q[$];
    int unsigned sz;
    if (i == 0) q = q0; else q = q1;
    if (r) begin
      q.delete();
      m_next[i]  = 0;
      m_en[i]    = 1'b0;
      m_baddr[i] = 0;
      m_din[i]   = '0;
    end else begin
      sz = q.size();
      if (sz > 0) begin
        m_din[i]   = q.pop_front();
        m_en[i]    = 1'b1;
        m_baddr[i] = m_next[i] * 4;
        m_next[i]  = (m_next[i] + 1) % ring_depth[i];
      end else begin
        m_en[i] = 1'b0;
      end
      if (w && sz < fifo_depth[i]) q.push_back(d);
    end
    if (i == 0) q0 = q; else q1 = q;
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] d);
    @(negedge clk);
    rst = r;
    fifo_write_en = w;
    fifo_write_data = d;
    @(posedge clk);
    model_edge(0, r, w, d);
    model_edge(1, r, w, d);
    #1;
    check("en0",    64'(ben0),   64'(m_en[0]));
    check("we0",    64'(bwe0),   m_en[0] ? 64'hF : 64'h0);
    check("addr0",  64'(baddr0), 64'(m_baddr[0]));
    check("din0",   64'(bdin0),  64'(m_din[0]));
    check("count0", 64'(count0), 64'(q0.size()));
    check("full0",  64'(full0),  64'(q0.size() == fifo_depth[0]));
    check("cur0",   64'(cur0),   64'(m_next[0]));
    check("en1",    64'(ben1),   64'(m_en[1]));
    check("we1",    64'(bwe1),   m_en[1] ? 64'hF : 64'h0);
    check("addr1",  64'(baddr1), 64'(m_baddr[1]));
    check("din1",   64'(bdin1),  64'(m_din[1]));
    check("count1", 64'(count1), 64'(q1.size()));
    check("full1",  64'(full1),  64'(q1.size() == fifo_depth[1]));
    check("cur1",   64'(cur1),   64'(m_next[1]));
    check("brst",   64'(brst0),  64'(r));
  endtask

  initial begin
    // reset and idle
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("rst_count", 64'(count0), 64'h0);
    check("rst_en",    64'(ben0),   64'h0);
    for (int unsigned k = 0; k < 3; k++) step(1'b0, 1'b0, '0);

    // single word: visible on the port one edge after the write
    step(1'b0, 1'b1, 32'hDEADBEEF);
    step(1'b0, 1'b0, '0);
    check("single_din",  64'(bdin0),  64'hDEADBEEF);
    check("single_addr", 64'(baddr0), 64'h0);
    check("single_en",   64'(ben0),   64'h1);
    step(1'b0, 1'b0, '0);
    check("single_cur",  64'(cur0),   64'h1);
    check("single_off",  64'(ben0),   64'h0);

    // 144-word burst
    step(1'b1, 1'b0, '0);
    for (int unsigned k = 0; k < 144; k++) step(1'b0, 1'b1, 32'(k));
    for (int unsigned k = 0; k < 3; k++) step(1'b0, 1'b0, '0);
    check("burst_cur0", 64'(cur0), 64'd144);
    check("burst_cur1", 64'(cur1), 64'd0);

    // 20 words into the 16-word ring
    step(1'b1, 1'b0, '0);
    for (int unsigned k = 0; k < 20; k++) step(1'b0, 1'b1, 32'h1000 + 32'(k));
    step(1'b0, 1'b0, '0);
    check("wrap_cur1",  64'(cur1),   64'd4);
    check("wrap_addr1", 64'(baddr1), 64'hC);
    check("wrap_din1",  64'(bdin1),  64'h1013);

    // reset mid-stream after three BRAM writes, write dropped by reset
    step(1'b1, 1'b0, '0);
    for (int unsigned k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h2000 + 32'(k));
    step(1'b1, 1'b1, 32'h2FFF);
    check("mid_count", 64'(count0), 64'h0);
    check("mid_en",    64'(ben0),   64'h0);
    for (int unsigned k = 4; k < 10; k++) step(1'b0, 1'b1, 32'h2000 + 32'(k));
    step(1'b0, 1'b0, '0);

    // random traffic with occasional resets
    for (int unsigned k = 0; k < 400; k++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom);
    for (int unsigned k = 0; k < 3; k++) step(1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_bram_bridge.md
Name: fifo_bram_bridge

Overview:
- Elastic buffer between a streaming 32-bit word producer (acquisition data generator) and a single-port BRAM (Port A of a dual-port buffer read by the PS).
- Accepts one word per cycle into a synchronous FIFO and drains it into the BRAM at sequential word addresses, wrapping at the buffer depth.
- Exposes FIFO fill level and next BRAM write address for the status register block.

Parameters:
- BRAM_ADDR_WIDTH, 16: BRAM byte-address width.
- BRAM_DATA_WIDTH, 32: BRAM data width; only 32 is supported.
- BRAM_DEPTH_WORDS, 16384: ring size in words; must be ≤ 2^(BRAM_ADDR_WIDTH-2).
- FIFO_DEPTH, 256: FIFO entries; must be a power of two.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; synchronous, active-high.
- fifo_write_en  in  1  write strobe for fifo_write_data.
- fifo_write_data  in  32  word to enqueue.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_count  out  $clog2(FIFO_DEPTH)+1 (9)  current occupancy, 0..FIFO_DEPTH.
- current_bram_address  out  BRAM_ADDR_WIDTH-2 (14)  word address of the next BRAM write.
- bram_clk  out  1  equals clk.
- bram_rst  out  1  equals rst.
- bram_addr  out  BRAM_ADDR_WIDTH  byte address, {word_addr, 2'b00}.
- bram_din  out  BRAM_DATA_WIDTH  write data.
- bram_en  out  1  BRAM enable, high only on write cycles.
- bram_we  out  4  byte write enables: 4'hF on write cycles, else 0.

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO pointers and fifo_count cleared to 0; fifo_full=0.
  - current_bram_address=0.
  - bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
  - Reset mid-stream discards all buffered words; the next write goes to address 0.
- Enqueue: at an edge with fifo_write_en=1 and FIFO not full, the word is stored and count increments. With FIFO full, the write is dropped: no state change, and no word is overwritten.
- Drain: at every edge where count>0 before the edge, the head word is popped and BRAM output registers are loaded:
  - bram_en=1, bram_we=4'hF, bram_din=head word.
  - bram_addr={current_bram_address, 2'b00}.
  - current_bram_address increments by 1.
  - At an edge with count=0, bram_en and bram_we are 0; bram_addr and bram_din hold their last values.
- Latency: a word written at edge N is visible on the BRAM port after edge N+1 (when the FIFO was empty) and is committed by the BRAM at edge N+2.
- Throughput: 1 word/cycle. A continuous writer keeps count at 1 and never fills the FIFO.
- Simultaneous enqueue and pop: count unchanged. Enqueue to a FIFO that was empty before the edge is not popped on that same edge; no fall-through.
- Address wrap: after writing word address BRAM_DEPTH_WORDS-1, current_bram_address becomes 0. With BRAM_DEPTH_WORDS < 2^(BRAM_ADDR_WIDTH-2), the wrap occurs at the parameter value, not at the power of two.
- All outputs except bram_clk and bram_rst are registered.
- fifo_full is derived from count (count==FIFO_DEPTH).
- No backpressure from the BRAM: every write is assumed to complete in one cycle.

Test Plan:
- Reset, then a single write of 0xDEADBEEF at edge N -> after N+1: bram_en=1, bram_we=F, bram_addr=0x0000, bram_din=0xDEADBEEF; after N+2: bram_en=0, current_bram_address=1, fifo_count=0.
- Burst of 144 consecutive writes (values 0..143) -> BRAM writes of values 0..143 at byte addresses 0x000..0x23C in order, one per cycle; fifo_count never exceeds 1; final current_bram_address=144.
- Wrap: BRAM_DEPTH_WORDS=16, write 20 words -> words 16..19 land at byte addresses 0x0,0x4,0x8,0xC; current_bram_address=4.
- Full/drop: hold bram drain by forcing rst-free fill test with FIFO_DEPTH=4 and an 8-word single-cycle-spaced burst while checking occupancy -> fifo_count ≤ 4; fifo_full asserts exactly when count=4; dropped writes never appear on bram_din.
- Reset mid-stream: 10 words written, rst pulsed after 3 BRAM writes -> count=0, bram_en=0 after the reset edge; next written word appears at bram_addr 0.
- Write while full and concurrent pop (FIFO_DEPTH=4, count=4, write_en=1) -> write dropped; count becomes 3; popped word is the oldest.
